// File: rtl/cvp_mem_pkg.sv
// Shared types and helpers for the CVP14 memory responder: FSM states, burst length, parity.
package cvp_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_SEQ = 2'd1,
    WR_SEQ = 2'd2
  } state_e;

  localparam int BURST_LEN = 16;

  // Even parity: stored bit makes the total count of ones in {par, data} even.
  function automatic logic par_even(input logic [15:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/cvp_mem_array.sv
// Word array: one synchronous write port, one registered read port, optional parity bit.
// Parity storage exists only when CVP_MEM_PARITY_EN is defined.
module cvp_mem_array
  import cvp_mem_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [15:0]   i_wdata,
`ifdef CVP_MEM_PARITY_EN
  input  logic          i_par_inv,
  output logic          o_par_mis,
`endif
  input  logic          i_re,
  input  logic          i_rzero,
  input  logic [AW-1:0] i_raddr,
  output logic [15:0]   o_rdata
);

  logic [15:0] r_mem [DEPTH];
`ifdef CVP_MEM_PARITY_EN
  logic        r_par [DEPTH];
`endif

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
`ifdef CVP_MEM_PARITY_EN
      r_par[i_waddr] <= par_even(i_wdata) ^ i_par_inv;
`endif
    end
  end

  // Read data holds when no read is accepted; out-of-range reads return zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_rdata <= 16'h0000;
    else if (i_re)
      o_rdata <= i_rzero ? 16'h0000 : r_mem[i_raddr];
  end

`ifdef CVP_MEM_PARITY_EN
  assign o_par_mis = (par_even(r_mem[i_raddr]) != r_par[i_raddr]);
`endif

endmodule

// File: rtl/cvp_mem_responder.sv
// CVP14 system-memory slave: arbitration, burst-tracking FSM and sticky status flags.
// Optional parity check/fault injection is enabled by defining CVP_MEM_PARITY_EN.
module cvp_mem_responder
  import cvp_mem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 4096,
  parameter int BURST_LEN = cvp_mem_pkg::BURST_LEN
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              RD,
  input  logic              WR,
  input  logic [15:0]       WrData,
  output logic [15:0]       RdData,
  input  logic              LdEn,
  input  logic [ADDR_W-1:0] LdAddr,
  input  logic [15:0]       LdData,
  output logic [3:0]        BurstCnt,
  output logic              BurstDone,
  output logic              OvrRange,
  output logic              ProtErr,
  output logic              Collision,
  output logic              ParErr
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] w_ld_addr;
  logic              w_cpu_in, w_ld_in, w_we, w_re, w_acc, w_consec;
  logic [AW-1:0]     w_waddr;
  logic [15:0]       w_wdata;
  logic [ADDR_W-1:0] w_prev_inc;
  state_e            w_dir;

  state_e            r_state;
  logic [ADDR_W-1:0] r_prev;
  logic [3:0]        r_cnt;
  logic              r_done, r_ovr, r_prot, r_coll;

`ifdef CVP_MEM_PARITY_EN
  // Top LdAddr bit is the fault-injection selector, not part of the address.
  logic w_par_mis;
  logic r_par_err;
  assign w_ld_addr = {1'b0, LdAddr[ADDR_W-2:0]};
`else
  assign w_ld_addr = LdAddr;
`endif

  assign w_cpu_in = ({1'b0, Addr} < DEPTH_C);
  assign w_ld_in  = ({1'b0, w_ld_addr} < DEPTH_C);
  // Host load owns the write port; a coincident CPU write is dropped.
  assign w_we     = LdEn ? w_ld_in : (WR & w_cpu_in);
  assign w_waddr  = LdEn ? w_ld_addr[AW-1:0] : Addr[AW-1:0];
  assign w_wdata  = LdEn ? LdData : WrData;
  assign w_re     = RD & ~WR;

  cvp_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .i_clk     (Clk),
    .i_rst_n   (Reset_n),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
`ifdef CVP_MEM_PARITY_EN
    .i_par_inv (LdAddr[ADDR_W-1]),
    .o_par_mis (w_par_mis),
`endif
    .i_re      (w_re),
    .i_rzero   (~w_cpu_in),
    .i_raddr   (Addr[AW-1:0]),
    .o_rdata   (RdData)
  );

  // A simultaneous RD&WR is a write for burst purposes.
  assign w_acc      = RD | WR;
  assign w_dir      = WR ? WR_SEQ : RD_SEQ;
  assign w_prev_inc = r_prev + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign w_consec   = (r_state == w_dir) && (Addr == w_prev_inc);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_prev  <= '0;
      r_cnt   <= 4'd0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
      r_prot  <= 1'b0;
      r_coll  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!w_acc) begin
        r_state <= IDLE;
        r_cnt   <= 4'd0;
      end else begin
        r_state <= w_dir;
        r_prev  <= Addr;
        if (!w_consec)
          r_cnt <= 4'd1;
        else if (r_cnt == 4'(BURST_LEN-1)) begin
          r_cnt  <= 4'd0;
          r_done <= 1'b1;
        end else
          r_cnt <= r_cnt + 4'd1;
      end
      if (RD & WR)           r_prot <= 1'b1;
      if (w_acc & ~w_cpu_in) r_ovr  <= 1'b1;
      if (LdEn & WR)         r_coll <= 1'b1;
    end
  end

`ifdef CVP_MEM_PARITY_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      r_par_err <= 1'b0;
    else if (w_re & w_cpu_in & w_par_mis)
      r_par_err <= 1'b1;
  end
  assign ParErr = r_par_err;
`else
  assign ParErr = 1'b0;
`endif

  assign BurstCnt  = r_cnt;
  assign BurstDone = r_done;
  assign OvrRange  = r_ovr;
  assign ProtErr   = r_prot;
  assign Collision = r_coll;

endmodule

// File: tb/tb_cvp_mem_responder.sv
// Directed bench for cvp_mem_responder with a read-data scoreboard queue.
module tb_cvp_mem_responder;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [15:0] Addr, WrData, RdData, LdAddr, LdData;
  logic        RD, WR, LdEn;
  logic [3:0]  BurstCnt;
  logic        BurstDone, OvrRange, ProtErr, Collision, ParErr;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] q_exp[$];
  logic [15:0] held;

  cvp_mem_responder dut (
    .Clk(Clk), .Reset_n(Reset_n), .Addr(Addr), .RD(RD), .WR(WR),
    .WrData(WrData), .RdData(RdData), .LdEn(LdEn), .LdAddr(LdAddr),
    .LdData(LdData), .BurstCnt(BurstCnt), .BurstDone(BurstDone),
    .OvrRange(OvrRange), .ProtErr(ProtErr), .Collision(Collision),
    .ParErr(ParErr)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    RD = 1'b0; WR = 1'b0; LdEn = 1'b0;
  endtask

  task automatic host_load(input logic [15:0] a, input logic [15:0] d);
    LdEn = 1'b1; LdAddr = a; LdData = d;
    tick();
    LdEn = 1'b0;
  endtask

  // Drive one read word, queue its expected data, compare on the following sample.
  task automatic rd_word(input string tag, input logic [15:0] a, input logic [15:0] exp);
    RD = 1'b1; WR = 1'b0; Addr = a;
    q_exp.push_back(exp);
    tick();
    if (q_exp.size() == 0) chk({tag, "_q"}, 16'd0, 16'd1);
    else chk(tag, RdData, q_exp.pop_front());
  endtask

  initial begin
    Reset_n = 1'b0; RD = 1'b0; WR = 1'b0; LdEn = 1'b0;
    Addr = '0; WrData = '0; LdAddr = '0; LdData = '0;
    #12;
    chk("rst_rddata", RdData, 16'h0);
    chk("rst_cnt", 16'(BurstCnt), 16'h0);
    chk("rst_flags", {11'd0, BurstDone, OvrRange, ProtErr, Collision, ParErr}, 16'h0);
    Reset_n = 1'b1;
    tick();

    // Single read after preload.
    host_load(16'h0010, 16'h4A08);
    rd_word("rd_single", 16'h0010, 16'h4A08);
    chk("cnt_single", 16'(BurstCnt), 16'd1);
    idle(); tick();
    chk("cnt_drop", 16'(BurstCnt), 16'd0);
    chk("rd_hold", RdData, 16'h4A08);

    // Write burst then read burst, directly back to back.
    for (int i = 0; i < 16; i++) begin
      WR = 1'b1; RD = 1'b0; Addr = 16'h0100 + 16'(i); WrData = 16'hA000 + 16'(i);
      tick();
      chk("wr_cnt", 16'(BurstCnt), 16'((i + 1) % 16));
      chk("wr_done", 16'(BurstDone), 16'(i == 15));
    end
    for (int i = 0; i < 16; i++) begin
      rd_word("rd_burst", 16'h0100 + 16'(i), 16'hA000 + 16'(i));
      chk("rd_cnt", 16'(BurstCnt), 16'((i + 1) % 16));
      chk("rd_done", 16'(BurstDone), 16'(i == 15));
    end
    idle(); tick();
    chk("burst_idle_cnt", 16'(BurstCnt), 16'd0);
    chk("burst_idle_done", 16'(BurstDone), 16'd0);

    // RD and WR together: write happens, read data holds.
    held = 16'hA00F;
    RD = 1'b1; WR = 1'b1; Addr = 16'h0020; WrData = 16'h1234;
    tick();
    chk("prot_hold", RdData, held);
    chk("prot_flag", 16'(ProtErr), 16'd1);
    rd_word("prot_rdback", 16'h0020, 16'h1234);

    // Host load beats a CPU write to a different address.
    idle();
    host_load(16'h0031, 16'h0BAD);
    LdEn = 1'b1; LdAddr = 16'h0030; LdData = 16'h5555;
    WR = 1'b1; Addr = 16'h0031; WrData = 16'h7777;
    tick();
    idle();
    chk("coll_flag", 16'(Collision), 16'd1);
    rd_word("coll_host", 16'h0030, 16'h5555);
    rd_word("coll_drop", 16'h0031, 16'h0BAD);

    // Out of range read, then address wrap FFFF -> 0000.
    idle(); tick();
    chk("ovr_clear", 16'(OvrRange), 16'd0);
    rd_word("ovr_rd", 16'h1000, 16'h0000);
    chk("ovr_flag", 16'(OvrRange), 16'd1);
    idle();
    host_load(16'h0000, 16'h00C3);
    rd_word("wrap_hi", 16'hFFFF, 16'h0000);
    chk("wrap_cnt1", 16'(BurstCnt), 16'd1);
    rd_word("wrap_lo", 16'h0000, 16'h00C3);
    chk("wrap_cnt2", 16'(BurstCnt), 16'd2);
    idle(); tick();

    // Reset in the middle of a write burst.
    for (int i = 0; i < 7; i++) begin
      WR = 1'b1; Addr = 16'h0200 + 16'(i); WrData = 16'hB000 + 16'(i);
      tick();
    end
    chk("pre_rst_cnt", 16'(BurstCnt), 16'd7);
    Addr = 16'h0207; WrData = 16'hB007;
    #2 Reset_n = 1'b0;
    #1;
    chk("mid_rst_rddata", RdData, 16'h0);
    chk("mid_rst_cnt", 16'(BurstCnt), 16'h0);
    chk("mid_rst_flags", {11'd0, BurstDone, OvrRange, ProtErr, Collision, ParErr}, 16'h0);
    idle(); tick();
    Reset_n = 1'b1;
    tick();
    for (int i = 0; i < 7; i++)
      rd_word("post_rst_rd", 16'h0200 + 16'(i), 16'hB000 + 16'(i));
    chk("post_rst_cnt", 16'(BurstCnt), 16'd7);
    idle(); tick();

`ifdef CVP_MEM_PARITY_EN
    host_load(16'h8040, 16'h0001);
    chk("par_pre", 16'(ParErr), 16'd0);
    rd_word("par_rd", 16'h0040, 16'h0001);
    chk("par_flag", 16'(ParErr), 16'd1);
`else
    host_load(16'h8040, 16'h0001);
    RD = 1'b1; Addr = 16'h0040;
    tick();
    chk("par_off", 16'(ParErr), 16'd0);
`endif
    idle(); tick();
    chk("q_empty", 16'(q_exp.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
